eight_queen_solution_checker: RTL and testbench

//  Receiving end of the N-queen solver output bus. Captures one board per frame, one
//  one-hot column mask per row, row 0 first. Checks every beat incrementally for the
//  one-hot rule and for column and diagonal conflicts, then reports a verdict.

---
 rtl/eight_queen_solution_checker.sv | 211 +++++++++++++++++++++
 tb/tb_eight_queen_solution_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/eight_queen_solution_checker.sv
// Eight-queen solution checker: captures one board per frame (one one-hot column
// mask per row, row 0 first), checks each beat for one-hot, column and diagonal
// conflicts, and reports a single verdict per frame. Holds the board for readback.
module eight_queen_solution_checker #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [N-1:0]         in_data,
    input  logic                 in_done,
    input  logic                 in_no_answer,
    output logic                 result_valid,
    output logic                 solution_ok,
    output logic [2:0]           err_code,
    output logic [$clog2(N)-1:0] err_row,
    output logic                 busy,
    input  logic [$clog2(N)-1:0] rd_row,
    output logic [$clog2(N)-1:0] rd_col
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int DN = 2 * N - 1;
    localparam int DW = $clog2(2 * N - 1);

    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_ONEHOT = 3'd1;
    localparam logic [2:0] E_COL   = 3'd2;
    localparam logic [2:0] E_DIAG  = 3'd3;
    localparam logic [2:0] E_SHORT = 3'd4;
    localparam logic [2:0] E_OVER  = 3'd5;
    localparam logic [2:0] E_NOANS = 3'd6;

    typedef enum logic [1:0] {IDLE, CAPTURE, REPORT} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [N-1:0]    col_used, col_used_next;
    logic [DN-1:0]   diag, diag_next;
    logic [DN-1:0]   adiag, adiag_next;
    logic            first_err, first_err_next;
    logic [2:0]      err_lat, err_lat_next;
    logic [RW-1:0]   err_row_lat, err_row_lat_next;
    logic            load_verdict;
    logic [2:0]      verdict_code;
    logic [RW-1:0]   verdict_row;
    logic            accept, close, store_en, beat_err;
    logic [2:0]      beat_code;
    logic [RW-1:0]   beat_row, beat_err_row, beat_col, rd_next;
    logic [DW-1:0]   diag_idx, adiag_idx;
    logic [RW-1:0]   board [N];

    assign busy = (state != IDLE);

    // Column index of the set bit in the incoming mask (only meaningful when one-hot).
    always_comb begin
        beat_col = '0;
        for (int i = 0; i < N; i++) begin
            if (in_data[i]) beat_col = i[RW-1:0];
        end
    end

    // Readback mux; rows outside the board read as 0.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_row == i[RW-1:0]) rd_next = board[i];
        end
    end

    // Next-state logic: frame open/close, per-beat legality check, verdict selection.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        col_used_next    = col_used;
        diag_next        = diag;
        adiag_next       = adiag;
        first_err_next   = first_err;
        err_lat_next     = err_lat;
        err_row_lat_next = err_row_lat;
        load_verdict     = 1'b0;
        verdict_code     = E_OK;
        verdict_row      = '0;
        accept           = 1'b0;
        close            = 1'b0;
        store_en         = 1'b0;
        beat_err         = 1'b0;
        beat_code        = E_OK;
        beat_err_row     = '0;
        beat_row         = '0;
        diag_idx         = '0;
        adiag_idx        = '0;

        case (state)
            IDLE: begin
                if (in_valid || in_done || in_no_answer) begin
                    // A new frame starts from clean masks and no recorded error.
                    cnt_next         = '0;
                    col_used_next    = '0;
                    diag_next        = '0;
                    adiag_next       = '0;
                    first_err_next   = 1'b0;
                    err_lat_next     = E_OK;
                    err_row_lat_next = '0;
                    accept           = in_valid;
                    close            = in_done || in_no_answer;
                    if (in_valid) state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                accept = in_valid;
                close  = in_done || in_no_answer;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The beat is processed before any close arriving in the same cycle.
        if (accept) begin
            beat_row = cnt_next[RW-1:0];
            if (cnt_next == CW'(N)) begin
                beat_err     = 1'b1;
                beat_code    = E_OVER;
                beat_err_row = RW'(N - 1);
            end else begin
                store_en  = 1'b1;
                diag_idx  = DW'(beat_row) + DW'(beat_col);
                // r + (N-1) >= c always, so this never wraps below zero.
                adiag_idx = DW'(beat_row) + DW'(N - 1) - DW'(beat_col);
                if ($countones(in_data) != 1) begin
                    beat_err  = 1'b1;
                    beat_code = E_ONEHOT;
                end else if (col_used_next[beat_col]) begin
                    beat_err  = 1'b1;
                    beat_code = E_COL;
                end else if (diag_next[diag_idx] || adiag_next[adiag_idx]) begin
                    beat_err  = 1'b1;
                    beat_code = E_DIAG;
                end else begin
                    col_used_next[beat_col] = 1'b1;
                    diag_next[diag_idx]     = 1'b1;
                    adiag_next[adiag_idx]   = 1'b1;
                end
                beat_err_row = beat_row;
                cnt_next     = cnt_next + CW'(1);
            end
            if (beat_err && !first_err_next) begin
                first_err_next   = 1'b1;
                err_lat_next     = beat_code;
                err_row_lat_next = beat_err_row;
            end
        end

        if (close) begin
            load_verdict = 1'b1;
            state_next   = REPORT;
            if (in_no_answer) begin
                verdict_code = E_NOANS;
                verdict_row  = '0;
            end else if (first_err_next) begin
                verdict_code = err_lat_next;
                verdict_row  = err_row_lat_next;
            end else if (cnt_next < CW'(N)) begin
                verdict_code = E_SHORT;
                verdict_row  = cnt_next[RW-1:0];
            end
        end
    end

    // Control, mask and verdict registers; verdict holds until the next frame closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            col_used     <= '0;
            diag         <= '0;
            adiag        <= '0;
            first_err    <= 1'b0;
            err_lat      <= E_OK;
            err_row_lat  <= '0;
            result_valid <= 1'b0;
            solution_ok  <= 1'b0;
            err_code     <= E_OK;
            err_row      <= '0;
            rd_col       <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            col_used     <= col_used_next;
            diag         <= diag_next;
            adiag        <= adiag_next;
            first_err    <= first_err_next;
            err_lat      <= err_lat_next;
            err_row_lat  <= err_row_lat_next;
            result_valid <= load_verdict;
            rd_col       <= rd_next;
            if (load_verdict) begin
                err_code    <= verdict_code;
                err_row     <= verdict_row;
                solution_ok <= (verdict_code == E_OK);
            end
        end
    end

    // Board store keeps the last captured columns across frames and resets.
    always_ff @(posedge clk) begin
        if (store_en) board[beat_row] <= beat_col;
    end

endmodule

// File: tb/tb_eight_queen_solution_checker.sv
// Directed bench for eight_queen_solution_checker with a verdict scoreboard.
module tb_eight_queen_solution_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_done = 1'b0;
    logic       in_no_answer = 1'b0;
    logic       result_valid;
    logic       solution_ok;
    logic [2:0] err_code;
    logic [2:0] err_row;
    logic       busy;
    logic [2:0] rd_row = 3'd0;
    logic [2:0] rd_col;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0] code;
        logic [2:0] row;
        logic       chk_row;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] legal [8] = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
    logic [2:0] legal_col [8] = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};

    `define CHK(tag, obs, expv) \
        begin \
            n_vec++; \
            assert ((obs) === (expv)) else begin \
                n_err++; \
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv); \
            end \
        end

    eight_queen_solution_checker #(.N(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_done      (in_done),
        .in_no_answer (in_no_answer),
        .result_valid (result_valid),
        .solution_ok  (solution_ok),
        .err_code     (err_code),
        .err_row      (err_row),
        .busy         (busy),
        .rd_row       (rd_row),
        .rd_col       (rd_col)
    );

    always #5 clk = ~clk;

    // Scoreboard: every verdict pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && result_valid === 1'b1) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_result observed=%0d expected=%0d", 1, 0);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                `CHK("err_code", err_code, e.code)
                `CHK("solution_ok", solution_ok, (e.code == 3'd0))
                if (e.chk_row) `CHK("err_row", err_row, e.row)
            end
        end
    end

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Drive the closing cycle, then check the one-cycle verdict pulse and return to idle.
    task automatic close_frame(input logic v, input logic [7:0] d, input logic done,
                               input logic na, input logic [2:0] code,
                               input logic [2:0] row, input logic chk_row);
        exp_t e;
        e.code = code; e.row = row; e.chk_row = chk_row;
        exp_q.push_back(e);
        in_valid     = v;
        in_data      = d;
        in_done      = done;
        in_no_answer = na;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        in_done      = 1'b0;
        in_no_answer = 1'b0;
        `CHK("verdict_latency", result_valid, 1'b1)
        `CHK("busy_report", busy, 1'b1)
        @(posedge clk); #1;
        `CHK("verdict_pulse_end", result_valid, 1'b0)
        `CHK("busy_idle", busy, 1'b0)
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        `CHK("rst_result_valid", result_valid, 1'b0)
        `CHK("rst_solution_ok", solution_ok, 1'b0)
        `CHK("rst_err_code", err_code, 3'd0)
        `CHK("rst_err_row", err_row, 3'd0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_rd_col", rd_col, 3'd0)
        reset = 1'b1;
        @(posedge clk); #1;

        // Legal board, separate done
        for (int i = 0; i < 8; i++) begin
            beat(legal[i]);
            if (i == 2) `CHK("busy_capture", busy, 1'b1)
        end
        `CHK("no_early_verdict", result_valid, 1'b0)
        close_frame(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1);

        // Readback of the legal board, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            rd_row = i[2:0];
            @(posedge clk); #1;
            `CHK("rd_col", rd_col, legal_col[i])
        end

        // Not one-hot at row 3
        beat(8'h01); beat(8'h10); beat(8'h80); beat(8'h03);
        beat(8'h04); beat(8'h40); beat(8'h02); beat(8'h08);
        close_frame(1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 3'd3, 1'b1);

        // Column clash at row 4
        beat(8'h01); beat(8'h10); beat(8'h80); beat(8'h20);
        beat(8'h01); beat(8'h40); beat(8'h02); beat(8'h08);
        close_frame(1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 3'd4, 1'b1);

        // Diagonal clash at row 1
        beat(8'h01); beat(8'h02); beat(8'h80); beat(8'h20);
        beat(8'h04); beat(8'h40); beat(8'h10); beat(8'h08);
        close_frame(1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 3'd1, 1'b1);

        // Short frame of five beats
        for (int i = 0; i < 5; i++) beat(legal[i]);
        close_frame(1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 3'd5, 1'b1);

        // Nine beats: overflow reported at the last row
        for (int i = 0; i < 8; i++) beat(legal[i]);
        beat(8'h01);
        close_frame(1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 3'd7, 1'b1);

        // Lone no-answer pulse
        close_frame(1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 3'd0, 1'b0);

        // Beat and done together in idle: one-row frame
        close_frame(1'b1, 8'h01, 1'b1, 1'b0, 3'd4, 3'd1, 1'b1);

        // No-answer beats done mid-frame
        for (int i = 0; i < 3; i++) beat(legal[i]);
        close_frame(1'b0, 8'h00, 1'b1, 1'b1, 3'd6, 3'd0, 1'b0);

        // Reset mid-frame discards the frame
        for (int i = 0; i < 4; i++) beat(legal[i]);
        reset = 1'b0;
        #1;
        `CHK("midreset_busy", busy, 1'b0)
        @(posedge clk); #1;
        `CHK("midreset_no_verdict", result_valid, 1'b0)
        reset = 1'b1;
        @(posedge clk); #1;
        `CHK("midreset_still_quiet", result_valid, 1'b0)

        // Legal board with the last beat and done in the same cycle
        for (int i = 0; i < 7; i++) beat(legal[i]);
        close_frame(1'b1, legal[7], 1'b1, 1'b0, 3'd0, 3'd0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL missing_verdicts observed=%0d expected=%0d", exp_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
